// File: rtl/muldiv_seq.sv
// Sequential 32-iteration unsigned multiply (shift-add) / divide (restoring)
// unit owning the architectural HI/LO registers.
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inum1,
  input  logic [31:0] inum2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  output logic [31:0] _hi,
  output logic [31:0] _lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        stall
);

  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] acc_hi, acc_lo, opnd;
  logic        op_div, dz_r;
  logic        valid_op, accept, zero_div, last;
  logic [32:0] sum, shl, diff;
  logic [31:0] it_hi, it_lo;

  assign valid_op = (op == OP_MULTU) || (op == OP_DIVU);
  assign accept   = start && valid_op && (state != S_RUN);
  assign zero_div = (op == OP_DIVU) && (inum2 == 32'd0);
  assign last     = (cnt == 6'(ITER - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (last) state_nxt = S_DONE;
      default: begin
        if (accept) state_nxt = zero_div ? S_DONE : S_RUN;
        else        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state == S_RUN);
    done     = (state == S_DONE);
    div_zero = done && dz_r;
    stall    = busy && (start || mthi || mtlo || rd_req);
  end

  // One iteration: multiply shifts the product right with a conditional add;
  // divide shifts remainder/quotient left and subtracts when no borrow.
  always_comb begin
    sum  = {1'b0, acc_hi} + {1'b0, opnd};
    shl  = {acc_hi, acc_lo[31]};
    diff = shl - {1'b0, opnd};
    if (op_div) begin
      if (!diff[32]) begin
        it_hi = diff[31:0];
        it_lo = {acc_lo[30:0], 1'b1};
      end else begin
        it_hi = shl[31:0];
        it_lo = {acc_lo[30:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {it_hi, it_lo} = {sum, acc_lo[31:1]};
    end else begin
      {it_hi, it_lo} = {1'b0, acc_hi, acc_lo[31:1]};
    end
  end

  // Datapath: partial results stay in acc_* until the final iteration commits
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      dz_r   <= 1'b0;
      _hi    <= '0;
      _lo    <= '0;
    end else if (state == S_RUN) begin
      acc_hi <= it_hi;
      acc_lo <= it_lo;
      cnt    <= cnt + 6'd1;
      if (last) begin
        _hi <= it_hi;
        _lo <= it_lo;
      end
    end else if (accept) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= (op == OP_DIVU) ? inum1 : inum2;
      opnd   <= (op == OP_DIVU) ? inum2 : inum1;
      op_div <= (op == OP_DIVU);
      dz_r   <= zero_div;
    end else begin
      if (mthi) _hi <= wdata;
      if (mtlo) _lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq: expected results queued at start,
// popped and checked on each done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, rd_req;
  logic [1:0]  op;
  logic [31:0] inum1, inum2, wdata;
  logic [31:0] _hi, _lo;
  logic        busy, done, div_zero, stall;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt;
  int          done_seen;

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .inum1(inum1), .inum2(inum2), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .rd_req(rd_req), ._hi(_hi), ._lo(_lo),
    .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (o == 2'd1) begin
      {e.hi, e.lo} = 64'(a) * 64'(b);
      e.dz = 1'b0; e.cyc = 32;
    end else if (b == 32'd0) begin
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.cyc = 0;
    end else begin
      e.hi = a % b; e.lo = a / b; e.dz = 1'b0; e.cyc = 32;
    end
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    start = 1'b1; op = o; inum1 = a; inum2 = b;
    busy_cnt = 0;
    step();
    start = 1'b0; op = 2'd0;
  endtask

  // Waits (bounded) for done, then compares against the oldest queued result
  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(_hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(_lo), 64'(e.lo));
      chk({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cyc));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; inum1 = '0; inum2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_req = 1'b0;
    m_hi = '0; m_lo = '0; busy_cnt = 0;
    step(); step();
    chk("rst_hilo", {_hi, _lo}, 64'(0));
    chk("rst_flags", 64'({busy, done, div_zero, stall}), 64'(0));
    reset = 1'b0;
    step();

    do_start(2'd1, 32'd7, 32'd6);
    wait_result("mul_7x6");
    step();
    chk("done_one_cycle", 64'(done), 64'(0));

    do_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("mul_max");
    step();

    do_start(2'd2, 32'd100, 32'd7);
    wait_result("div_100_7");
    step();
    do_start(2'd2, 32'd5, 32'd0);
    wait_result("div_zero");
    step();
    chk("dz_one_cycle", 64'({done, div_zero}), 64'(0));

    // Direct writes in IDLE
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    mthi = 1'b0; m_hi = 32'hDEAD_BEEF;
    chk("mthi_idle", 64'(_hi), 64'(m_hi));
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    step();
    mthi = 1'b0; mtlo = 1'b0; m_hi = wdata; m_lo = wdata;
    chk("mthi_mtlo_both", {_hi, _lo}, {m_hi, m_lo});

    // Invalid ops are ignored
    for (int k = 0; k < 4; k += 3) begin
      start = 1'b1; op = 2'(k); inum1 = 32'd9; inum2 = 32'd9;
      step();
      start = 1'b0;
      chk("bad_op_no_busy", 64'({busy, done}), 64'(0));
    end
    chk("bad_op_hilo", {_hi, _lo}, {m_hi, m_lo});

    // mtlo + rd_req during RUN stalls and does not write LO
    do_start(2'd1, 32'd3, 32'd4);
    mtlo = 1'b1; rd_req = 1'b1; wdata = 32'h5555_5555;
    #1;
    chk("stall_run", 64'(stall), 64'(1));
    step();
    chk("mtlo_blocked", 64'(_lo), 64'(32'h1234_5678));
    mtlo = 1'b0; rd_req = 1'b0;
    #1;
    chk("stall_released", 64'(stall), 64'(0));
    wait_result("mul_3x4");
    step();

    // start with mthi in the same cycle: start wins, HI not written
    mthi = 1'b1; wdata = 32'hCAFE_F00D;
    begin
      logic [31:0] hi_before;
      hi_before = _hi;
      do_start(2'd1, 32'd2, 32'd5);
      mthi = 1'b0;
      chk("start_beats_mthi", 64'(_hi), 64'(hi_before));
    end
    wait_result("mul_2x5");
    step();

    // Reset mid-RUN: discard, no done
    do_start(2'd1, 32'd3, 32'd3);
    void'(sb.pop_back());
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1; mthi = 1'b1; wdata = 32'h7777_7777;
    step();
    reset = 1'b0; mthi = 1'b0; m_hi = '0; m_lo = '0;
    chk("rst_mid_hilo", {_hi, _lo}, 64'(0));
    chk("rst_mid_busy", 64'({busy, done}), 64'(0));
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) done_seen++;
    end
    chk("rst_no_done", 64'(done_seen), 64'(0));

    // Back-to-back start in the DONE cycle
    do_start(2'd1, 32'd7, 32'd6);
    wait_result("b2b_first");
    do_start(2'd2, 32'd9, 32'd3);
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_result("b2b_div_9_3");
    step();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
